audio_nios_key_event_ctrl: RTL and testbench

//  Avalon-MM key-event controller for the 4 DE2-115 push-buttons (active-low KEY[3:0]).

---
 rtl/audio_nios_key_pkg.sv | 54 +++++
 rtl/audio_nios_key_debounce.sv | 122 ++++++++++++
 rtl/audio_nios_key_event_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_audio_nios_key_event_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_nios_key_pkg.sv
// ---------------------------------------------------------------------------
// audio_nios_key_pkg - shared constants, key FSM states and event layout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package audio_nios_key_pkg;

   localparam int NUM_KEYS = 4;

   // Avalon-MM word addresses
   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_EVENT  = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_CMD    = 2'd3;

   typedef enum logic [1:0] {
      UP     = 2'd0,
      CHK_DN = 2'd1,
      DOWN   = 2'd2,
      CHK_UP = 2'd3
   } key_state_t;

   // Event word fields
   localparam int EVT_W         = 4;
   localparam int EVT_IDX_LSB   = 0;
   localparam int EVT_IDX_W     = 2;
   localparam int EVT_PRESS_BIT = 2;
   localparam int EVT_RPT_BIT   = 3;

   // Register fields
   localparam int ST_LEVEL_LSB    = 0;
   localparam int ST_COUNT_LSB    = 4;
   localparam int ST_COUNT_W      = 7;
   localparam int ST_OVF_BIT      = 11;
   localparam int EV_VALID_BIT    = 31;
   localparam int CTRL_IRQ_EN_BIT = 0;
   localparam int CMD_CLR_OVF_BIT = 0;
   localparam int CMD_FLUSH_BIT   = 1;

   function automatic logic [EVT_W-1:0] make_event(input logic [EVT_IDX_W-1:0] idx,
                                                   input logic press,
                                                   input logic rpt);
      logic [EVT_W-1:0] ev;
      ev = '0;
      ev[EVT_IDX_LSB +: EVT_IDX_W] = idx;
      ev[EVT_PRESS_BIT]            = press;
      ev[EVT_RPT_BIT]              = rpt;
      return ev;
   endfunction

endpackage

`default_nettype wire

// File: rtl/audio_nios_key_debounce.sv
// ---------------------------------------------------------------------------
// audio_nios_key_debounce - one key: tick-driven debounce FSM with event strobes.
// KEY_AUTOREPEAT_EN adds a repeat counter while the key is held. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module audio_nios_key_debounce
   import audio_nios_key_pkg::*;
#(
   parameter int DEB_TICKS = 20
`ifdef KEY_AUTOREPEAT_EN
  ,parameter int REPEAT_TICKS = 500
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic key_s,
   output logic level,
   output logic press,
   output logic rel,
   output logic rpt
);

   localparam logic [7:0] DEB_LAST = 8'(DEB_TICKS);

   key_state_t state, state_nx;
   logic [7:0] cnt, cnt_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= UP;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      press    = 1'b0;
      rel      = 1'b0;
      if (tick) begin
         case (state)
            UP: begin
               if (key_s) begin
                  state_nx = CHK_DN;
                  cnt_nx   = 8'd1;
               end
            end
            CHK_DN: begin
               if (!key_s) begin
                  state_nx = UP;
                  cnt_nx   = '0;
               end else if (cnt == DEB_LAST) begin
                  state_nx = DOWN;
                  cnt_nx   = '0;
                  press    = 1'b1;
               end else begin
                  cnt_nx = cnt + 8'd1;
               end
            end
            DOWN: begin
               if (!key_s) begin
                  state_nx = CHK_UP;
                  cnt_nx   = 8'd1;
               end
            end
            CHK_UP: begin
               if (key_s) begin
                  state_nx = DOWN;
                  cnt_nx   = '0;
               end else if (cnt == DEB_LAST) begin
                  state_nx = UP;
                  cnt_nx   = '0;
                  rel      = 1'b1;
               end else begin
                  cnt_nx = cnt + 8'd1;
               end
            end
            default: begin
               state_nx = UP;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   assign level = (state == DOWN) || (state == CHK_UP);

`ifdef KEY_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_TICKS) + 1;
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);

   logic [RW-1:0] rcnt;
   logic          rwrap;

   assign rwrap = (rcnt == RPT_LAST);

   // The period keeps running through CHK_UP so a brief bounce does not restart it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rcnt <= '0;
      end else if (tick) begin
         if (state == CHK_DN && state_nx == DOWN) begin
            rcnt <= '0;
         end else if (state == DOWN || state == CHK_UP) begin
            rcnt <= rwrap ? '0 : rcnt + RW'(1);
         end
      end
   end

   assign rpt = tick && (state == DOWN) && key_s && rwrap;
`else
   assign rpt = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/audio_nios_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// audio_nios_key_event_ctrl - Avalon-MM debounced key-event controller with event FIFO.
// Optional KEY_AUTOREPEAT_EN: held keys emit repeat press events. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module audio_nios_key_event_ctrl
   import audio_nios_key_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int DEB_TICKS  = 20,
   parameter int FIFO_DEPTH = 8
`ifdef KEY_AUTOREPEAT_EN
  ,parameter int REPEAT_TICKS = 500
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] writedata,
   input  logic [3:0]  in_port,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   // Input synchroniser; idles at 1 = released
   logic [NUM_KEYS-1:0] sync1, sync2, key_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   assign key_s = ~sync2;

   logic [PW-1:0] pre;
   logic          tick;

   assign tick = (pre == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre <= '0;
      end else begin
         pre <= tick ? '0 : pre + PW'(1);
      end
   end

   logic [NUM_KEYS-1:0] key_level, ev_new, ev_press, ev_rpt;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      logic press, rel, rpt;

      audio_nios_key_debounce #(
         .DEB_TICKS    (DEB_TICKS)
`ifdef KEY_AUTOREPEAT_EN
        ,.REPEAT_TICKS (REPEAT_TICKS)
`endif
      ) u_deb (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .key_s (key_s[i]),
         .level (key_level[i]),
         .press (press),
         .rel   (rel),
         .rpt   (rpt)
      );

      assign ev_new[i]   = press | rel | rpt;
      assign ev_press[i] = press | rpt;
      assign ev_rpt[i]   = rpt;
   end

   logic rd_strobe, wr_strobe, flush, clr_ovf, pop, push, drop, pend_ovf;
   logic fifo_nonempty, fifo_full;
   logic [CW-1:0] count;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [EVT_W-1:0] mem [FIFO_DEPTH];
   logic overflow, irq_en;

   assign rd_strobe = chipselect & ~read_n;
   assign wr_strobe = chipselect & ~write_n;
   assign flush     = wr_strobe & (address == ADDR_CMD) & writedata[CMD_FLUSH_BIT];
   assign clr_ovf   = wr_strobe & (address == ADDR_CMD) & writedata[CMD_CLR_OVF_BIT];

   assign fifo_nonempty = (count != '0);
   assign fifo_full     = (count == CW'(FIFO_DEPTH));
   assign pop           = rd_strobe & (address == ADDR_EVENT) & fifo_nonempty;

   // One pending event per key, granted lowest index first
   logic [NUM_KEYS-1:0]  pend_v, pend_press, pend_rpt, gnt_oh;
   logic [EVT_IDX_W-1:0] gnt_idx;
   logic                 gnt_any;
   logic [EVT_W-1:0]     gnt_evt;

   always_comb begin
      gnt_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (pend_v[i]) gnt_idx = EVT_IDX_W'(i);
      end
   end

   assign gnt_any  = |pend_v;
   assign gnt_oh   = pend_v & (~pend_v + NUM_KEYS'(1));
   assign gnt_evt  = make_event(gnt_idx, pend_press[gnt_idx], pend_rpt[gnt_idx]);
   assign push     = gnt_any & ~flush & (~fifo_full | pop);
   assign drop     = gnt_any & ~flush & fifo_full & ~pop;
   assign pend_ovf = ~flush & (|(ev_new & pend_v & ~gnt_oh));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_v     <= '0;
         pend_press <= '0;
         pend_rpt   <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (flush) begin
               pend_v[i] <= 1'b0;
            end else if (ev_new[i]) begin
               pend_v[i]     <= 1'b1;
               pend_press[i] <= ev_press[i];
               pend_rpt[i]   <= ev_rpt[i];
            end else if (gnt_oh[i]) begin
               pend_v[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= gnt_evt;
   end

   // A fresh loss outranks a clear issued in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (pend_ovf | drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en <= 1'b0;
      end else if (wr_strobe && address == ADDR_CTRL) begin
         irq_en <= writedata[CTRL_IRQ_EN_BIT];
      end
   end

   logic [31:0] status_word, event_word;

   always_comb begin
      status_word = '0;
      status_word[ST_LEVEL_LSB +: NUM_KEYS]  = key_level;
      status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count);
      status_word[ST_OVF_BIT]                = overflow;
      event_word = '0;
      if (fifo_nonempty) begin
         event_word[EVT_W-1:0]    = mem[rd_ptr];
         event_word[EV_VALID_BIT] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else if (rd_strobe) begin
         case (address)
            ADDR_STATUS: readdata <= status_word;
            ADDR_EVENT:  readdata <= event_word;
            ADDR_CTRL:   readdata <= {31'd0, irq_en};
            default:     readdata <= '0;
         endcase
      end
   end

   assign irq = irq_en & fifo_nonempty;

   logic unused_wdata;
   assign unused_wdata = ^writedata[31:2];

endmodule

`default_nettype wire

// File: tb/tb_audio_nios_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_audio_nios_key_event_ctrl - scoreboard bench for the key-event controller.
// Honours KEY_AUTOREPEAT_EN for the repeat-event expectations. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_audio_nios_key_event_ctrl;
   import audio_nios_key_pkg::*;

   localparam int TICK = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [3:0]  in_port = 4'hF;
   logic [31:0] readdata;
   logic        irq;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      string       name;
   } exp_t;

   exp_t sb[$];
   logic rd_d = 1'b0;

   audio_nios_key_event_ctrl #(
      .TICK_DIV     (4),
      .DEB_TICKS    (3),
      .FIFO_DEPTH   (8)
`ifdef KEY_AUTOREPEAT_EN
     ,.REPEAT_TICKS (10)
`endif
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_d <= chipselect & ~read_n;

   // Monitor: readdata is presented the cycle after each read strobe
   always @(negedge clk) begin
      if (rd_d) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: readdata=%h with no expectation queued", readdata);
         end else begin
            e = sb.pop_front();
            if (readdata !== e.data) begin
               errors++;
               $display("FAIL %s: readdata=%h required %h", e.name, readdata, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] req, input string name);
      exp_t e;
      e.data = req;
      e.name = name;
      @(posedge clk); #1;
      sb.push_back(e);
      address    = a;
      chipselect = 1'b1;
      read_n     = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0;
      read_n     = 1'b1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic ticks(input int n);
      repeat (n * TICK) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // 1: reset state
      chk("reset_readdata", readdata, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      rd(ADDR_STATUS, 32'h0, "t1_status");
      rd(ADDR_EVENT, 32'h0, "t1_event_empty");

      // 2: bouncing key0 yields exactly one press
      wr(ADDR_CTRL, 32'd1);
      rd(ADDR_CTRL, 32'd1, "t2_ctrl_readback");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_port[0] = ~in_port[0];
      end
      ticks(7);
      chk("t2_irq_pending", {31'd0, irq}, 32'd1);
      rd(ADDR_EVENT, 32'h80000004, "t2_press");
      chk("t2_irq_after_pop", {31'd0, irq}, 32'd0);
      rd(ADDR_STATUS, 32'h001, "t2_status_held");
      rd(ADDR_EVENT, 32'h0, "t2_single_event");
      in_port[0] = 1'b1;
      ticks(7);
      rd(ADDR_EVENT, 32'h80000000, "t2_release");

      // 3: short glitch on key1 is rejected
      in_port[1] = 1'b0;
      ticks(2);
      in_port[1] = 1'b1;
      ticks(6);
      chk("t3_irq_quiet", {31'd0, irq}, 32'd0);
      rd(ADDR_STATUS, 32'h0, "t3_status");
      rd(ADDR_EVENT, 32'h0, "t3_no_event");

      // 4: simultaneous keys 1 and 2 arbitrate lowest index first
      in_port = 4'b1001;
      ticks(7);
      rd(ADDR_STATUS, 32'h026, "t4_status_two");
      rd(ADDR_EVENT, 32'h80000005, "t4_press_k1");
      rd(ADDR_EVENT, 32'h80000006, "t4_press_k2");
      in_port = 4'hF;
      ticks(7);
      rd(ADDR_STATUS, 32'h020, "t4_status_rel");
      rd(ADDR_EVENT, 32'h80000001, "t4_rel_k1");
      rd(ADDR_EVENT, 32'h80000002, "t4_rel_k2");

      // 5: ten events into an eight-entry FIFO
      for (int i = 0; i < 5; i++) begin
         in_port[0] = 1'b0;
         ticks(7);
         in_port[0] = 1'b1;
         ticks(7);
      end
      rd(ADDR_STATUS, 32'h880, "t5_status_full_ovf");
      for (int i = 0; i < 8; i++) begin
         rd(ADDR_EVENT, (i % 2 == 0) ? 32'h80000004 : 32'h80000000, $sformatf("t5_event%0d", i));
      end
      rd(ADDR_STATUS, 32'h800, "t5_status_drained");
      wr(ADDR_CMD, 32'd1);
      rd(ADDR_STATUS, 32'h0, "t5_status_cleared");

      // Flush discards queued events but not the debounced level
      in_port[0] = 1'b0;
      ticks(7);
      rd(ADDR_STATUS, 32'h011, "flush_status_before");
      wr(ADDR_CMD, 32'd2);
      rd(ADDR_STATUS, 32'h001, "flush_status_after");
      chk("flush_irq", {31'd0, irq}, 32'd0);
      rd(ADDR_EVENT, 32'h0, "flush_event_empty");
      in_port[0] = 1'b1;
      ticks(7);
      rd(ADDR_EVENT, 32'h80000000, "flush_release_after");
      rd(ADDR_CMD, 32'h0, "cmd_reads_zero");

      // 6: long hold on key3
      in_port[3] = 1'b0;
      ticks(30);
      in_port[3] = 1'b1;
      ticks(7);
      rd(ADDR_EVENT, 32'h80000007, "t6_press");
`ifdef KEY_AUTOREPEAT_EN
      rd(ADDR_EVENT, 32'h8000000F, "t6_repeat1");
      rd(ADDR_EVENT, 32'h8000000F, "t6_repeat2");
`endif
      rd(ADDR_EVENT, 32'h80000003, "t6_release");
      rd(ADDR_EVENT, 32'h0, "t6_empty");

      repeat (3) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d reads outstanding, required 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
